// File: rtl/vcop_issue_if.sv
// Op-intake and issue handshake bundle between the vsi op source, the issue
// controller and the vector datapath.
interface vcop_issue_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [31:0]     vsi_op;
    logic            vsi_lmul;
    logic            vsi_sew;
    logic            vsi_op_valid;
    logic            vsi_op_ready;
    logic            vsi_cop_idle;
    logic            iss_valid;
    logic            iss_ready;
    logic [31:0]     iss_op;
    logic            iss_lmul;
    logic            iss_sew;
    logic [CntW-1:0] q_count;

    // Op source plus datapath side.
    modport master (
        output vsi_op, vsi_lmul, vsi_sew, vsi_op_valid, iss_ready,
        input  vsi_op_ready, vsi_cop_idle, iss_valid, iss_op, iss_lmul, iss_sew, q_count
    );

    // Issue controller side.
    modport slave (
        input  vsi_op, vsi_lmul, vsi_sew, vsi_op_valid, iss_ready,
        output vsi_op_ready, vsi_cop_idle, iss_valid, iss_op, iss_lmul, iss_sew, q_count
    );
endinterface

// File: rtl/vcop_issue_ctrl.sv
// In-order issue controller for the vector coprocessor: an op queue feeding the
// datapath, gated by a per-register write-busy scoreboard so that multi-cycle
// ops overlap with independent ones while RAW/WAR/WAW hazards stall.
module vcop_issue_ctrl #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LAT_W       = 3,
    parameter int unsigned LAT_VXOR    = 1,
    parameter int unsigned LAT_VMACC   = 3,
    parameter int unsigned LAT_VRED    = 4,
    parameter int unsigned LAT_VSLIDE  = 2,
    parameter int unsigned LAT_VGATHER = 2,
    parameter int unsigned LAT_DEF     = 1
) (
    input logic         vsi_clk,
    input logic         vsi_rst,
    vcop_issue_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [31:0] op;
        logic        lmul;
        logic        sew;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [LAT_W-1:0] busy_q [32];
    logic [LAT_W-1:0] busy_d [32];

    entry_t           head;
    logic             empty, push, pop, hazard, any_busy, iss_valid;
    logic [4:0]       vd, vs1, vs2;
    logic [LAT_W-1:0] lat;

    // Membership of register r in the group named by field f.
    function automatic logic in_grp(logic [4:0] r, logic [4:0] f, logic lmul);
        return lmul ? (r[4:1] == f[4:1]) : (r == f);
    endfunction

    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);
    assign vd    = head.op[11:7];
    assign vs1   = head.op[19:15];
    assign vs2   = head.op[24:20];

    assign bus.vsi_op_ready = (count_q != CntW'(DEPTH));
    assign push             = bus.vsi_op_valid & bus.vsi_op_ready;
    // Reset wins over issue so nothing leaves the queue in the reset cycle.
    assign iss_valid        = !empty && !hazard && !vsi_rst;
    assign pop              = iss_valid & bus.iss_ready;

    assign bus.iss_valid    = iss_valid;
    assign bus.iss_op       = empty ? '0 : head.op;
    assign bus.iss_lmul     = empty ? 1'b0 : head.lmul;
    assign bus.iss_sew      = empty ? 1'b0 : head.sew;
    assign bus.q_count      = count_q;
    assign bus.vsi_cop_idle = empty && !any_busy;

    // Hazard detection: any busy register in the head's vs1, vs2 or vd group.
    always_comb begin
        hazard   = 1'b0;
        any_busy = 1'b0;
        for (int r = 0; r < 32; r++) begin
            if (busy_q[r] != '0) begin
                any_busy = 1'b1;
                if (in_grp(5'(r), vs1, head.lmul) || in_grp(5'(r), vs2, head.lmul) ||
                    in_grp(5'(r), vd, head.lmul)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Write latency of the head op, selected by funct6.
    always_comb begin
        case (head.op[31:26])
            6'b001011: lat = LAT_W'(LAT_VXOR);
            6'b101101: lat = LAT_W'(LAT_VMACC);
            6'b000000: lat = LAT_W'(LAT_VRED);
            6'b001110: lat = LAT_W'(LAT_VSLIDE);
            6'b001100: lat = LAT_W'(LAT_VGATHER);
            default:   lat = LAT_W'(LAT_DEF);
        endcase
    end

    // Scoreboard next state: issue loads the vd group, otherwise count down.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            busy_d[r] = busy_q[r];
            if (pop && in_grp(5'(r), vd, head.lmul)) begin
                busy_d[r] = lat;
            end else if (busy_q[r] != '0) begin
                busy_d[r] = busy_q[r] - LAT_W'(1);
            end
        end
    end

    // Queue pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
    end

    // Control state with synchronous reset.
    always_ff @(posedge vsi_clk) begin
        if (vsi_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int r = 0; r < 32; r++) begin
                busy_q[r] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int r = 0; r < 32; r++) begin
                busy_q[r] <= busy_d[r];
            end
        end
    end

    // Queue storage; contents are only meaningful below the occupancy count.
    always_ff @(posedge vsi_clk) begin
        if (push && !vsi_rst) begin
            mem_q[wr_ptr_q] <= '{op: bus.vsi_op, lmul: bus.vsi_lmul, sew: bus.vsi_sew};
        end
    end
endmodule
